nms_stream: RTL and testbench

Streaming 3x3 non-maximum suppression for FAST9 corner scores. Accepts one score per cycle in raster order and keeps two line buffers plus a 3x3 window. Emits each surviving corner with its score and linear pixel address. Sits between the FAST9 score stage and the corner writeback. It replaces the purely combinational 8-neighbour comparator with a self-addressing, frame-aware, back-pressurable unit.

---
 rtl/nms_stream.sv | 140 ++++++++++++++
 tb/tb_nms_stream.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/nms_stream.sv
// nms_stream: streaming 3x3 non-maximum suppression for FAST9 corner scores.
//
// Takes one score per accepted pixel in raster order. Two line buffers and a
// 3x3 window hold the neighbourhood. Each surviving corner is emitted with its
// score and its linear address row*IMG_W+col.
//
// Optional build macro: NMS_STRICT_TIE_EN. When it is defined, the centre must
// be strictly greater than the neighbours above it and to its left. This makes
// a plateau of equal scores produce exactly one corner.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   in_valid   in   in_score/in_sof valid this cycle
//   in_ready   out  block can accept a pixel
//   in_sof     in   first pixel of frame; forces row 0, col 0
//   in_score   in   FAST9 score, 0 = not a corner
//   out_valid  out  corner available
//   out_ready  in   downstream accepts corner
//   out_addr   out  linear address of corner centre
//   out_score  out  score of corner centre
//   frame_done out  one-cycle pulse after the last pixel of a frame
module nms_stream #(
    parameter int IMG_W   = 180,
    parameter int IMG_H   = 120,
    parameter int SCORE_W = 8,
    parameter int ADDR_W  = 15
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_sof,
    input  logic [SCORE_W-1:0] in_score,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ADDR_W-1:0]  out_addr,
    output logic [SCORE_W-1:0] out_score,
    output logic               frame_done
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0]     COL_LAST   = CW'(IMG_W - 1);
    localparam logic [RW-1:0]     ROW_LAST   = RW'(IMG_H - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] CENTRE_OFS = ADDR_W'(IMG_W + 1);

    logic [CW-1:0]      col_q, col_d, cur_col;
    logic [RW-1:0]      row_q, row_d, cur_row;
    logic [ADDR_W-1:0]  base_q, base_d, cur_base;
    logic [SCORE_W-1:0] lb0_mem [IMG_W];
    logic [SCORE_W-1:0] lb1_mem [IMG_W];
    // win_q[line][col]: line 0 = row r-2, 1 = row r-1, 2 = row r;
    // col 0 = column c-2, col 1 = column c-1. Column c arrives live.
    logic [SCORE_W-1:0] win_q [3][2];
    logic [SCORE_W-1:0] win_d [3][2];
    logic [SCORE_W-1:0] up_px, mid_px, centre;
    logic               accept, last_col, last_row, in_window, upper_ok, lower_ok, fire;
    logic               out_valid_q, out_valid_d, frame_done_q, frame_done_d;
    logic [ADDR_W-1:0]  out_addr_q, out_addr_d;
    logic [SCORE_W-1:0] out_score_q, out_score_d;

    always_comb begin
        in_ready = !out_valid_q || out_ready;
        accept   = in_valid && in_ready;
        // A start-of-frame pixel overrides the counters so the block resyncs.
        cur_col  = in_sof ? '0 : col_q;
        cur_row  = in_sof ? '0 : row_q;
        cur_base = in_sof ? '0 : base_q;
        last_col = cur_col == COL_LAST;
        last_row = cur_row == ROW_LAST;
        up_px    = lb1_mem[cur_col];
        mid_px   = lb0_mem[cur_col];
        centre   = win_q[1][1];
`ifdef NMS_STRICT_TIE_EN
        upper_ok = centre > win_q[0][0] && centre > win_q[0][1] && centre > up_px
                   && centre > win_q[1][0];
`else
        upper_ok = centre >= win_q[0][0] && centre >= win_q[0][1] && centre >= up_px
                   && centre >= win_q[1][0];
`endif
        lower_ok = centre >= mid_px && centre >= win_q[2][0] && centre >= win_q[2][1]
                   && centre >= in_score;
        // Centre (r-1,c-1) is interior only when r>=2 and c>=2; the c>=2 test
        // also masks windows that straddle a row wrap.
        in_window = cur_row >= RW'(2) && cur_col >= CW'(2);
        fire      = accept && in_window && centre != '0 && upper_ok && lower_ok;
        col_d  = accept ? (last_col ? '0 : cur_col + CW'(1)) : col_q;
        row_d  = !accept ? row_q : !last_col ? cur_row : last_row ? '0 : cur_row + RW'(1);
        base_d = !accept ? base_q : !last_col ? cur_base : last_row ? '0 : cur_base + ROW_STEP;
        win_d  = win_q;
        if (accept) begin
            win_d[0][0] = win_q[0][1];
            win_d[0][1] = up_px;
            win_d[1][0] = win_q[1][1];
            win_d[1][1] = mid_px;
            win_d[2][0] = win_q[2][1];
            win_d[2][1] = in_score;
        end
        out_valid_d  = fire || (out_valid_q && !out_ready);
        out_addr_d   = fire ? cur_base + ADDR_W'(cur_col) - CENTRE_OFS : out_addr_q;
        out_score_d  = fire ? centre : out_score_q;
        frame_done_d = accept && last_row && last_col;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_q        <= '0;
            row_q        <= '0;
            base_q       <= '0;
            win_q        <= '{default: '0};
            out_valid_q  <= 1'b0;
            out_addr_q   <= '0;
            out_score_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            base_q       <= base_d;
            win_q        <= win_d;
            out_valid_q  <= out_valid_d;
            out_addr_q   <= out_addr_d;
            out_score_q  <= out_score_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Line buffers are plain RAMs with no reset; the row counter decides validity.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1_mem[cur_col] <= mid_px;
            lb0_mem[cur_col] <= in_score;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_addr   = out_addr_q;
    assign out_score  = out_score_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_nms_stream.sv
// tb_nms_stream: randomized scoreboard bench for nms_stream against a frame-level model.
module tb_nms_stream;
    localparam int W = 8, H = 6, SW = 8, AW = 15, N = W * H;

    logic clk = 0, reset_n = 0, in_valid = 0, in_sof = 0, out_ready = 0;
    logic in_ready, out_valid, frame_done;
    logic [SW-1:0] in_score = '0, out_score;
    logic [AW-1:0] out_addr;

    always #5 clk = ~clk;

    nms_stream #(.IMG_W(W), .IMG_H(H), .SCORE_W(SW), .ADDR_W(AW)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_sof(in_sof), .in_score(in_score), .out_valid(out_valid),
        .out_ready(out_ready), .out_addr(out_addr), .out_score(out_score),
        .frame_done(frame_done)
    );

    int chk_cnt = 0, pass_cnt = 0, fd_cnt = 0, fd_exp = 0;
    int rdy_mode = 0, lat_idx = -1;
    bit stall_req = 0, pend_fd = 0, pend_ov = 0, pend_nov = 0;
    logic [AW-1:0] pend_addr = '0;
    logic [AW+SW-1:0] exp_q[$];
    logic [SW-1:0] fr[N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        chk_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    // Expected corners of the whole frame in fr, in raster order of the centre.
    function automatic void model();
        logic [SW-1:0] ctr, nb;
        bit ok, strict;
        for (int r = 1; r < H - 1; r++)
            for (int c = 1; c < W - 1; c++) begin
                ctr = fr[r*W+c];
                ok = ctr != 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if (dr != 0 || dc != 0) begin
                            nb = fr[(r+dr)*W+c+dc];
`ifdef NMS_STRICT_TIE_EN
                            strict = dr < 0 || (dr == 0 && dc < 0);
`else
                            strict = 0;
`endif
                            ok = ok && (strict ? ctr > nb : ctr >= nb);
                        end
                if (ok) exp_q.push_back({AW'(r*W+c), ctr});
            end
    endfunction

    // Drive one input cycle (v=0 for a gap); returns at posedge+1 after acceptance.
    task automatic step(input logic v, input logic sof, input logic [SW-1:0] s);
        int n = 0;
        in_valid = v; in_sof = sof; in_score = s;
        @(negedge clk);
        if (pend_fd) chk("frame_done_pulse", frame_done, 1);
        if (pend_ov) begin
            chk("latency_valid", out_valid, 1);
            chk("latency_addr", out_addr, pend_addr);
        end
        if (pend_nov) chk("early_valid", out_valid, 0);
        pend_fd = 0; pend_ov = 0; pend_nov = 0;
        while (v && !in_ready) begin
            @(posedge clk); @(negedge clk);
            if (++n > 2000) begin
                $display("FAIL in_ready_timeout: got stuck, expected acceptance");
                $fatal(1, "timeout");
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic run_frame(input int upto, input bit gaps);
        for (int i = 0; i < upto; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) step(0, 0, 0);
            step(1, i == 0, fr[i]);
            if (i == N - 1) begin pend_fd = 1; fd_exp++; end
            if (i == lat_idx) pend_ov = 1;
            if (i == lat_idx - 1) pend_nov = 1;
        end
        in_valid = 0; in_sof = 0;
        if (upto == N) step(0, 0, 0);
    endtask

    task automatic fill(input int maxv);
        for (int i = 0; i < N; i++) fr[i] = SW'($urandom_range(0, maxv));
    endtask

    always @(negedge clk) if (frame_done) fd_cnt++;

    // Sink: pops the scoreboard on every transfer and drives out_ready.
    initial begin
        logic [AW+SW-1:0] e;
        logic [AW-1:0] ha;
        logic [SW-1:0] hs;
        forever begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk_cnt++;
                    $display("FAIL unexpected_corner: got addr %0d score %0d, expected none", out_addr, out_score);
                end else begin
                    e = exp_q.pop_front();
                    chk("corner_addr", out_addr, e[AW+SW-1:SW]);
                    chk("corner_score", out_score, e[SW-1:0]);
                end
            end
            if (stall_req && out_valid && !out_ready) begin
                ha = out_addr; hs = out_score;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    chk("stall_in_ready", in_ready, 0);
                    chk("stall_hold", {out_valid, out_addr, out_score}, {1'b1, ha, hs});
                end
                stall_req = 0;
            end
            @(posedge clk); #1;
            out_ready = stall_req ? 1'b0 : rdy_mode == 1 ? 1'b1 : ($urandom_range(0, 2) != 0);
        end
    end

    initial begin
        #12;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_addr", out_addr, 0);
        chk("reset_out_score", out_score, 0);
        chk("reset_frame_done", frame_done, 0);
        #5 reset_n = 1;
        @(posedge clk); #1;
        chk("idle_in_ready", in_ready, 1);

        // All-zero frame: no corners, one frame_done.
        rdy_mode = 1;
        fr = '{default: '0};
        model(); run_frame(N, 0);

        // Single corner with exact latency: centre (2,3) appears after pixel (3,4).
        fr = '{default: '0}; fr[19] = 50;
        lat_idx = 28; pend_addr = 19;
        model(); run_frame(N, 0);
        lat_idx = -1;

        // Neighbour suppression and border scores.
        rdy_mode = 0;
        fr = '{default: '0}; fr[19] = 40; fr[20] = 41; fr[3] = 99; fr[23] = 99;
        model(); run_frame(N, 1);

        // Plateau of two equal scores.
        fr = '{default: '0}; fr[19] = 30; fr[20] = 30;
        model(); run_frame(N, 1);

        // Stray start-of-frame: a partial frame of large scores is abandoned.
        fr = '{default: 8'd200};
        run_frame(12, 0);
        fill(6);
        model(); run_frame(N, 1);

        // Back-pressure: hold the first corner for five cycles while input waits.
        fill(6); fr[10] = 200;
        stall_req = 1;
        model(); run_frame(N, 0);
        chk("stall_seen", 32'(stall_req), 0);

        // Random frames with small scores (many ties), gaps and random out_ready.
        for (int f = 0; f < 6; f++) begin
            fill(f < 3 ? 4 : 15);
            model(); run_frame(N, 1);
        end

        // Asynchronous reset in row 3 with a corner pending, then a clean frame.
        rdy_mode = 1;
        fill(6); fr[17] = 200;
        model(); run_frame(27, 0);
        chk("pre_reset_valid", out_valid, 1);
        chk("pre_reset_addr", out_addr, 17);
        #1 reset_n = 0;
        #1;
        chk("async_reset_valid", out_valid, 0);
        chk("async_reset_addr", out_addr, 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #2 reset_n = 1;
        @(posedge clk); #1;
        rdy_mode = 0;
        fill(10);
        model(); run_frame(N, 1);

        repeat (20) step(0, 0, 0);
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("frame_done_count", fd_cnt, fd_exp);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
